// File: rtl/ball_controller_if.sv
// Handshake/status bundle between the ball controller and its neighbours.
// The master side drives the per-frame event inputs; the slave side is the controller.
interface ball_controller_if;
    logic       i_FrameTick;
    logic       i_Start;
    logic       i_XDir;
    logic       i_YDir;
    logic       i_PaddleHit;
    logic       i_Miss;
    logic [9:0] o_BallX;
    logic [9:0] o_BallY;
    logic [2:0] o_Speed;
    logic [1:0] o_Misses;
    logic [1:0] o_State;

    modport master (
        output i_FrameTick, i_Start, i_XDir, i_YDir, i_PaddleHit, i_Miss,
        input  o_BallX, o_BallY, o_Speed, o_Misses, o_State
    );

    modport slave (
        input  i_FrameTick, i_Start, i_XDir, i_YDir, i_PaddleHit, i_Miss,
        output o_BallX, o_BallY, o_Speed, o_Misses, o_State
    );
endinterface

// File: rtl/ball_controller.sv
// Pong ball controller: IDLE/SERVE/PLAY sequencing, clamped per-frame motion, miss counting.
// Optional BALL_SPEEDUP_EN adds a speed increase every fourth paddle hit.
module ball_controller #(
    parameter int H_AREA       = 640,
    parameter int V_AREA       = 480,
    parameter int BALL_SIZE    = 8,
    parameter int SERVE_FRAMES = 60,
    parameter int BASE_SPEED   = 1,
    parameter int MAX_SPEED    = 4,
    parameter int MAX_MISSES   = 3
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    ball_controller_if.slave   bus
);
    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [9:0]        START_X    = 10'((H_AREA - BALL_SIZE) / 2);
    localparam logic [9:0]        START_Y    = 10'((V_AREA - BALL_SIZE) / 2);
    localparam logic signed [10:0] X_MAX_S   = 11'(H_AREA - BALL_SIZE);
    localparam logic signed [10:0] Y_MAX_S   = 11'(V_AREA - BALL_SIZE);
    localparam logic [2:0]        BASE_SPD   = 3'(BASE_SPEED);
    localparam logic [1:0]        MAX_M      = 2'(MAX_MISSES);
    localparam logic [CNT_W-1:0]  SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SERVE = 2'd1, S_PLAY = 2'd2} state_e;

    state_e            state_q, state_d;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic [2:0]        speed_q, speed_d;
    logic [1:0]        misses_q, misses_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [1:0]        misses_inc;
    logic              serve_entry;
    logic signed [10:0] x_mv, y_mv;
    logic [9:0]        x_nx, y_nx;
`ifdef BALL_SPEEDUP_EN
    localparam logic [2:0] MAX_SPD = 3'(MAX_SPEED);
    logic [1:0]        hit_cnt_q, hit_cnt_d;
`else
    logic              unused_paddle_hit;
    assign unused_paddle_hit = bus.i_PaddleHit;
`endif

    assign misses_inc = (misses_q == MAX_M) ? misses_q : misses_q + 2'd1;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q     <= S_IDLE;
            x_q         <= START_X;
            y_q         <= START_Y;
            speed_q     <= BASE_SPD;
            misses_q    <= '0;
            frame_cnt_q <= '0;
`ifdef BALL_SPEEDUP_EN
            hit_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            speed_q     <= speed_d;
            misses_q    <= misses_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef BALL_SPEEDUP_EN
            hit_cnt_q   <= hit_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.i_Start) state_d = S_SERVE;
            S_SERVE: if (bus.i_FrameTick && frame_cnt_q == SERVE_LAST) state_d = S_PLAY;
            S_PLAY:  if (bus.i_Miss) state_d = (misses_inc == MAX_M) ? S_IDLE : S_SERVE;
            default: state_d = S_IDLE;
        endcase
    end

    assign serve_entry = (state_d == S_SERVE) && (state_q != S_SERVE);

    always_comb begin
        // Signed 11-bit step so a move past the left/top edge shows up negative before clamping.
        x_mv = bus.i_XDir ? $signed({1'b0, x_q}) + $signed({8'd0, speed_q})
                          : $signed({1'b0, x_q}) - $signed({8'd0, speed_q});
        y_mv = bus.i_YDir ? $signed({1'b0, y_q}) + $signed({8'd0, speed_q})
                          : $signed({1'b0, y_q}) - $signed({8'd0, speed_q});
        if (x_mv < 11'sd0)        x_nx = '0;
        else if (x_mv > X_MAX_S)  x_nx = X_MAX_S[9:0];
        else                      x_nx = x_mv[9:0];
        if (y_mv < 11'sd0)        y_nx = '0;
        else if (y_mv > Y_MAX_S)  y_nx = Y_MAX_S[9:0];
        else                      y_nx = y_mv[9:0];

        x_d         = x_q;
        y_d         = y_q;
        speed_d     = speed_q;
        misses_d    = misses_q;
        frame_cnt_d = frame_cnt_q;
`ifdef BALL_SPEEDUP_EN
        hit_cnt_d   = hit_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                x_d = START_X;
                y_d = START_Y;
                if (bus.i_Start) misses_d = '0;
            end
            S_SERVE: if (bus.i_FrameTick) frame_cnt_d = frame_cnt_q + CNT_W'(1);
            S_PLAY: begin
                // A miss pre-empts both motion and hit counting in the same cycle.
                if (bus.i_Miss) begin
                    misses_d = misses_inc;
                    x_d      = START_X;
                    y_d      = START_Y;
                end else begin
                    if (bus.i_FrameTick) begin
                        x_d = x_nx;
                        y_d = y_nx;
                    end
`ifdef BALL_SPEEDUP_EN
                    if (bus.i_PaddleHit) begin
                        hit_cnt_d = hit_cnt_q + 2'd1;
                        if (hit_cnt_q == 2'd3 && speed_q < MAX_SPD) speed_d = speed_q + 3'd1;
                    end
`endif
                end
            end
            default: ;
        endcase

        if (serve_entry) begin
            x_d         = START_X;
            y_d         = START_Y;
            speed_d     = BASE_SPD;
            frame_cnt_d = '0;
`ifdef BALL_SPEEDUP_EN
            hit_cnt_d   = '0;
`endif
        end
    end

    assign bus.o_BallX  = x_q;
    assign bus.o_BallY  = y_q;
    assign bus.o_Speed  = speed_q;
    assign bus.o_Misses = misses_q;
    assign bus.o_State  = state_q;
endmodule
